// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : stopwatch_ctrl                                                |
// | Description : Run/pause/adjust controller for a min:sec stopwatch; owns the |
// |               seconds counter and pulses the external minutes counter.     |
// |               Optional adjust mode is built when STOPWATCH_CTRL_ADJ_EN is   |
// |               defined.                                                      |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module stopwatch_ctrl #(
    parameter int TICK_DIV = 100000000,
    parameter int ADJ_DIV  = 50000000
) (
    input  logic       clkctl,
    input  logic       rstctl,
    input  logic       pause_p,
    input  logic       adj,
    input  logic       sel,
    output logic       enablesec,
    output logic       overflow,
    output logic       enablemin,
    output logic [5:0] countsec,
    output logic [1:0] state
);

    localparam logic [1:0]  c_idle      = 2'b00;
    localparam logic [1:0]  c_run       = 2'b01;
    localparam logic [1:0]  c_pause     = 2'b10;
    localparam logic [1:0]  c_adjust    = 2'b11;
    localparam logic [26:0] c_tick_last = 27'(TICK_DIV - 1);
    localparam logic [5:0]  c_sec_last  = 6'd59;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [26:0] r_div;
    logic [5:0]  r_countsec;
    logic [5:0]  w_sec_inc;
    logic        r_enablesec;
    logic        r_overflow;
    logic        r_enablemin;
    logic        w_adj_req;
    logic        w_adj_entry;
    logic        w_run_tick;
    logic        w_adj_sec_tick;
    logic        w_adj_min_tick;

`ifdef STOPWATCH_CTRL_ADJ_EN
    localparam logic [26:0] c_adj_last = 27'(ADJ_DIV - 1);

    logic [26:0] r_adiv;
    logic        w_adj_tick;

    assign w_adj_req      = adj;
    assign w_adj_tick     = (r_state == c_adjust) && (r_adiv == c_adj_last);
    // sel is sampled on the tick itself, so a mid-adjust change waits for the next tick
    assign w_adj_sec_tick = w_adj_tick && sel;
    assign w_adj_min_tick = w_adj_tick && !sel;

    always_ff @(posedge clkctl) begin
        if (rstctl) begin
            r_adiv <= 27'd0;
        end else if (w_adj_entry) begin
            r_adiv <= 27'd0;
        end else if (r_state == c_adjust) begin
            r_adiv <= w_adj_tick ? 27'd0 : r_adiv + 27'd1;
        end
    end
`else
    logic w_unused_adj;

    assign w_unused_adj   = adj ^ sel;
    assign w_adj_req      = 1'b0;
    assign w_adj_sec_tick = 1'b0;
    assign w_adj_min_tick = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        if (w_adj_req) begin
            w_state_nxt = c_adjust;
        end else if (r_state == c_adjust) begin
            w_state_nxt = c_pause;
        end else if (pause_p) begin
            case (r_state)
                c_idle:  w_state_nxt = c_run;
                c_run:   w_state_nxt = c_pause;
                c_pause: w_state_nxt = c_run;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    assign w_adj_entry = (w_state_nxt == c_adjust) && (r_state != c_adjust);
    assign w_run_tick  = (r_state == c_run) && (r_div == c_tick_last);
    assign w_sec_inc   = (r_countsec == c_sec_last) ? 6'd0 : r_countsec + 6'd1;

    always_ff @(posedge clkctl) begin
        if (rstctl) begin
            r_state     <= c_idle;
            r_div       <= 27'd0;
            r_countsec  <= 6'd0;
            r_enablesec <= 1'b0;
            r_overflow  <= 1'b0;
            r_enablemin <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_enablesec <= 1'b0;
            r_overflow  <= 1'b0;
            r_enablemin <= 1'b0;

            // div only moves in RUN, so PAUSE keeps the sub-second phase
            if (w_adj_entry) begin
                r_div <= 27'd0;
            end else if (r_state == c_run) begin
                r_div <= w_run_tick ? 27'd0 : r_div + 27'd1;
            end

            if (w_run_tick) begin
                r_enablesec <= 1'b1;
                r_overflow  <= (r_countsec == c_sec_last);
                r_countsec  <= w_sec_inc;
            end else if (w_adj_sec_tick) begin
                r_enablesec <= 1'b1;
                r_countsec  <= w_sec_inc;
            end else if (w_adj_min_tick) begin
                r_enablemin <= 1'b1;
            end
        end
    end

    assign enablesec = r_enablesec;
    assign overflow  = r_overflow;
    assign enablemin = r_enablemin;
    assign countsec  = r_countsec;
    assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_stopwatch_ctrl                                             |
// | Description : Directed bench for stopwatch_ctrl with a cycle-level model    |
// |               (TICK_DIV=4, ADJ_DIV=2); follows STOPWATCH_CTRL_ADJ_EN.       |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_stopwatch_ctrl;

    localparam int TICK_DIV = 4;
    localparam int ADJ_DIV  = 2;
`ifdef STOPWATCH_CTRL_ADJ_EN
    localparam bit ADJ_EN = 1'b1;
`else
    localparam bit ADJ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pause_p = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic       enablesec;
    logic       overflow;
    logic       enablemin;
    logic [5:0] countsec;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int em_cnt;

    stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .ADJ_DIV(ADJ_DIV)) dut (
        .clkctl    (clk),
        .rstctl    (rst),
        .pause_p   (pause_p),
        .adj       (adj),
        .sel       (sel),
        .enablesec (enablesec),
        .overflow  (overflow),
        .enablemin (enablemin),
        .countsec  (countsec),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 run, 2 pause, 3 adjust; ticks fall on every
    // TICK_DIV-th clock spent running / every ADJ_DIV-th clock spent adjusting.
    int m_mode = 0;
    int m_runclk = 0;
    int m_adjclk = 0;
    int m_sec = 0;
    bit m_es = 1'b0;
    bit m_ov = 1'b0;
    bit m_em = 1'b0;

    always @(posedge clk) begin
        int nxt;
        m_es = 1'b0;
        m_ov = 1'b0;
        m_em = 1'b0;
        if (rst) begin
            m_mode = 0; m_runclk = 0; m_adjclk = 0; m_sec = 0;
        end else begin
            if (ADJ_EN && adj)           nxt = 3;
            else if (m_mode == 3)        nxt = 2;
            else if (pause_p && m_mode == 1) nxt = 2;
            else if (pause_p)            nxt = 1;
            else                         nxt = m_mode;
            if (m_mode == 1) begin
                m_runclk++;
                if (m_runclk % TICK_DIV == 0) begin
                    m_es = 1'b1;
                    m_ov = (m_sec == 59);
                    m_sec = (m_sec + 1) % 60;
                end
            end else if (m_mode == 3) begin
                m_adjclk++;
                if (m_adjclk % ADJ_DIV == 0) begin
                    if (sel) begin
                        m_es = 1'b1;
                        m_sec = (m_sec + 1) % 60;
                    end else begin
                        m_em = 1'b1;
                    end
                end
            end
            if (nxt == 3 && m_mode != 3) begin
                m_runclk = 0;
                m_adjclk = 0;
            end
            m_mode = nxt;
        end
    end

    always @(negedge clk) begin
        logic [10:0] exp_v;
        logic [10:0] act_v;
        if (chk_en) begin
            exp_v = {2'(m_mode), 6'(m_sec), m_es, m_ov, m_em};
            act_v = {state, countsec, enablesec, overflow, enablemin};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL model_cmp t=%0t: got st=%b sec=%0d es=%b ov=%b em=%b, expected st=%b sec=%0d es=%b ov=%b em=%b",
                         $time, act_v[10:9], act_v[8:3], act_v[2], act_v[1], act_v[0],
                         exp_v[10:9], exp_v[8:3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input bit p, input bit a, input bit s);
        pause_p = p;
        adj = a;
        sel = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        step(0, 0, 0);
        step(0, 0, 0);
        chk_en = 1'b1;
        chk("rst_state", state, 0);
        chk("rst_countsec", countsec, 0);
        chk("rst_pulses", {enablesec, overflow, enablemin}, 0);
        rst = 1'b0;

        // first tick exactly TICK_DIV clocks after start
        step(1, 0, 0);
        chk("run_state", state, 1);
        for (int i = 1; i <= 12; i++) begin
            step(0, 0, 0);
            chk("run_es", enablesec, (i % 4 == 0) ? 1 : 0);
            if (i % 4 == 0) chk("run_sec", countsec, i / 4);
        end

        // 3 -> 58 -> 59 -> 0 with overflow
        for (int i = 0; i < 220; i++) step(0, 0, 0);
        chk("sec_58", countsec, 58);
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        chk("sec_59", countsec, 59);
        chk("ov_59", overflow, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        chk("ov_pre", overflow, 0);
        step(0, 0, 0);
        chk("wrap_sec", countsec, 0);
        chk("wrap_ov_es", {overflow, enablesec}, 3);
        step(0, 0, 0);
        chk("ov_clear", overflow, 0);

        // pause two cycles after a tick, resume: tick 2 clocks later
        step(1, 0, 0);
        chk("pause_state", state, 2);
        for (int i = 0; i < 10; i++) step(0, 0, 0);
        chk("pause_sec", countsec, 0);
        step(1, 0, 0);
        chk("resume_state", state, 1);
        step(0, 0, 0);
        chk("resume_es1", enablesec, 0);
        step(0, 0, 0);
        chk("resume_es2", enablesec, 1);
        chk("resume_sec", countsec, 1);

`ifdef STOPWATCH_CTRL_ADJ_EN
        // adjust minutes: four enablemin pulses, seconds frozen
        step(1, 1, 0);
        chk("adj_state", state, 3);
        em_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0);
            em_cnt += enablemin;
        end
        chk("adj_em_count", em_cnt, 4);
        chk("adj_sec_hold", countsec, 1);
        for (int i = 0; i < 116; i++) step(0, 1, 1);
        chk("adj_sec_59", countsec, 59);
        step(0, 1, 1);
        step(0, 1, 1);
        chk("adj_wrap_sec", countsec, 0);
        chk("adj_wrap_es_ov", {enablesec, overflow}, 2);
        step(0, 0, 1);
        chk("adj_exit_state", state, 2);
        step(0, 1, 0);
        step(0, 1, 0);
`else
        // adj ignored: pause_p still toggles run/pause
        step(1, 1, 0);
        chk("noadj_pause", state, 2);
        step(1, 1, 1);
        chk("noadj_run", state, 1);
        em_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, i[0]);
            em_cnt += enablemin;
        end
        chk("noadj_em", em_cnt, 0);
`endif

        // reset with coincident pause_p wins
        rst = 1'b1;
        step(1, 1, 0);
        rst = 1'b0;
        chk("rst2_state", state, 0);
        chk("rst2_sec", countsec, 0);
        chk("rst2_pulses", {enablesec, overflow, enablemin}, 0);
        step(0, 0, 0);
        chk("rst2_idle", state, 0);
        step(1, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 0);
            chk("rst2_first_tick", enablesec, (i == 4) ? 1 : 0);
        end
        step(0, 0, 0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
